// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the fetch and load/store requesters.
// Build option MEM_ARB_ROUND_ROBIN_EN: ties go to the port not granted last.
// Without it, load/store always beats fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic last_gnt,
  output logic gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, alternate away from whoever was served last.
  always_comb begin
    gnt = GNT_IF;
    if (if_req && ls_req) begin
      gnt = (last_gnt == GNT_LS) ? GNT_IF : GNT_LS;
    end else if (ls_req) begin
      gnt = GNT_LS;
    end
  end
`else
  // Fixed priority: any load/store request wins over a fetch.
  always_comb begin
    gnt = GNT_IF;
    if (ls_req) begin
      gnt = GNT_LS;
    end
  end

  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt ^ if_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port unified memory between instruction fetch
// and load/store. Each grant runs IDLE -> ACCESS -> DONE; memory pins, read
// data, done pulses and busy are all driven from registers.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  output logic [DW-1:0] ls_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  mem_arb_state_t state, state_next;

  logic          gnt, gnt_next;
  logic          last_gnt, last_gnt_next;
  logic          pick_gnt;
  logic [AW-1:0] mem_a_next;
  logic [DW-1:0] mem_wd_next;
  logic          mem_we_next;
  logic          if_done_next, ls_done_next;
  logic [DW-1:0] if_rdata_next, ls_rdata_next;
  logic          busy_next;

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .ls_req   (ls_req),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    last_gnt_next = last_gnt;
    mem_a_next    = mem_a;
    mem_wd_next   = mem_wd;
    mem_we_next   = 1'b0;
    if_done_next  = 1'b0;
    ls_done_next  = 1'b0;
    if_rdata_next = if_rdata;
    ls_rdata_next = ls_rdata;

    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          state_next    = ACCESS;
          gnt_next      = pick_gnt;
          last_gnt_next = pick_gnt;
          if (pick_gnt == GNT_LS) begin
            mem_a_next  = ls_addr;
            mem_wd_next = ls_wdata;
            mem_we_next = ls_we;
          end else begin
            mem_a_next  = if_addr;
            mem_wd_next = '0;
          end
        end
      end
      ACCESS: begin
        state_next = DONE;
        if (gnt == GNT_IF) begin
          if_rdata_next = mem_rd;
          if_done_next  = 1'b1;
        end else begin
          if (!mem_we) begin
            ls_rdata_next = mem_rd;
          end
          ls_done_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // Output and bookkeeping registers; last grant resets to LS so IF wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt      <= GNT_IF;
      last_gnt <= GNT_LS;
      mem_a    <= '0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      gnt      <= gnt_next;
      last_gnt <= last_gnt_next;
      mem_a    <= mem_a_next;
      mem_wd   <= mem_wd_next;
      mem_we   <= mem_we_next;
      if_done  <= if_done_next;
      ls_done  <= ls_done_next;
      if_rdata <= if_rdata_next;
      ls_rdata <= ls_rdata_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural memory/arbitration model.
// Honors MEM_ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_mem_arbiter;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       if_req = 1'b0;
  logic [7:0] if_addr = 8'h00;
  logic       if_done;
  logic [7:0] if_rdata;
  logic       ls_req = 1'b0;
  logic       ls_we = 1'b0;
  logic [7:0] ls_addr = 8'h00;
  logic [7:0] ls_wdata = 8'h00;
  logic       ls_done;
  logic [7:0] ls_rdata;
  logic [7:0] mem_a;
  logic [7:0] mem_wd;
  logic       mem_we;
  logic [7:0] mem_rd;
  logic       busy;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_done  (ls_done),
    .ls_rdata (ls_rdata),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment memory: synchronous write, combinational read.
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end
  assign mem_rd = mem[mem_a];

  typedef struct {
    logic       port;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ls_rdata = 8'h00;
  logic       ref_last = PORT_LS;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic model_winner(input logic i_req, input logic l_req);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && l_req) return (ref_last == PORT_LS) ? PORT_IF : PORT_LS;
`else
    if (i_req && l_req) return PORT_LS;
`endif
    return l_req ? PORT_LS : PORT_IF;
  endfunction

  // Reference model: called in grant order, updates memory and LS read data.
  function automatic void model_push(input logic port, input logic [7:0] addr,
                                     input logic we, input logic [7:0] wdata,
                                     input int done_cyc);
    exp_t e;
    e.port = port;
    e.addr = addr;
    e.we = (port == PORT_LS) && we;
    e.wdata = wdata;
    e.done_cyc = done_cyc;
    if (port == PORT_IF) begin
      e.rdata = ref_mem[addr];
    end else if (we) begin
      ref_mem[addr] = wdata;
      e.rdata = ref_ls_rdata;
    end else begin
      e.rdata = ref_mem[addr];
      ref_ls_rdata = e.rdata;
    end
    ref_last = port;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops on each done pulse, checks memory pins during ACCESS.
  exp_t mon_e;
  always @(negedge clock) begin
    if (!reset) begin
      if (if_done || ls_done) begin
        checkOutput("we_in_done", {31'd0, mem_we}, 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", {30'd0, if_done, ls_done}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("done_port", {30'd0, if_done, ls_done},
                      (mon_e.port == PORT_LS) ? 32'd1 : 32'd2);
          checkOutput("done_cycle", cyc, mon_e.done_cyc);
          if (mon_e.port == PORT_IF) checkOutput("if_rdata", {24'd0, if_rdata}, {24'd0, mon_e.rdata});
          else                       checkOutput("ls_rdata", {24'd0, ls_rdata}, {24'd0, mon_e.rdata});
        end
      end else if (busy) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_access", {31'd0, busy}, 32'd0);
        end else begin
          mon_e = exp_q[0];
          checkOutput("access_addr", {24'd0, mem_a}, {24'd0, mon_e.addr});
          checkOutput("access_we", {31'd0, mem_we}, {31'd0, mon_e.we});
          if (mon_e.we) checkOutput("access_wd", {24'd0, mem_wd}, {24'd0, mon_e.wdata});
        end
      end else if (mem_we) begin
        checkOutput("we_outside_access", {31'd0, mem_we}, 32'd0);
      end
    end
  end

  task automatic waitIdle();
    int k;
    k = 0;
    @(negedge clock);
    while (busy && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (busy) checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic waitDone(input logic port);
    int k;
    for (k = 0; k < 12; k++) begin
      @(negedge clock);
      if ((port == PORT_IF) ? if_done : ls_done) break;
    end
    if (k == 12) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic driveReq(input logic port, input logic [7:0] addr, input logic we,
                          input logic [7:0] wdata);
    if (port == PORT_IF) begin
      if_addr = addr;
      if_req = 1'b1;
    end else begin
      ls_addr = addr;
      ls_we = we;
      ls_wdata = wdata;
      ls_req = 1'b1;
    end
  endtask

  task automatic dropReq(input logic port);
    if (port == PORT_IF) if_req = 1'b0;
    else                 ls_req = 1'b0;
  endtask

  // One transaction from an idle arbiter, req dropped as soon as done is seen.
  task automatic applyStimulus(input logic port, input logic [7:0] addr, input logic we,
                               input logic [7:0] wdata);
    waitIdle();
    model_push(port, addr, we, wdata, cyc + 2);
    driveReq(port, addr, we, wdata);
    waitDone(port);
    dropReq(port);
  endtask

  // Both ports request together; second grant lands three cycles after the first.
  task automatic runPair(input logic from_reset, input logic [7:0] ia, input logic lwe,
                         input logic [7:0] la, input logic [7:0] lwd);
    logic first;
    int   d;
    if (from_reset) begin
      driveReq(PORT_IF, ia, 1'b0, 8'h00);
      driveReq(PORT_LS, la, lwe, lwd);
      @(negedge clock);
      reset = 1'b0;
    end else begin
      waitIdle();
      driveReq(PORT_IF, ia, 1'b0, 8'h00);
      driveReq(PORT_LS, la, lwe, lwd);
    end
    d = cyc;
    first = model_winner(1'b1, 1'b1);
    if (first == PORT_IF) begin
      model_push(PORT_IF, ia, 1'b0, 8'h00, d + 2);
      model_push(PORT_LS, la, lwe, lwd, d + 5);
    end else begin
      model_push(PORT_LS, la, lwe, lwd, d + 2);
      model_push(PORT_IF, ia, 1'b0, 8'h00, d + 5);
    end
    waitDone(first);
    dropReq(first);
    waitDone(~first);
    dropReq(~first);
  endtask

  task automatic busyTest(input logic [7:0] ia, input logic [7:0] la);
    int d;
    waitIdle();
    d = cyc;
    model_push(PORT_IF, ia, 1'b0, 8'h00, d + 2);
    driveReq(PORT_IF, ia, 1'b0, 8'h00);
    @(negedge clock);
    model_push(PORT_LS, la, 1'b0, 8'h00, d + 5);
    driveReq(PORT_LS, la, 1'b0, 8'h00);
    waitDone(PORT_IF);
    dropReq(PORT_IF);
    waitDone(PORT_LS);
    dropReq(PORT_LS);
  endtask

  task automatic keepHighTest(input logic [7:0] ia);
    int d;
    waitIdle();
    d = cyc;
    model_push(PORT_IF, ia, 1'b0, 8'h00, d + 2);
    model_push(PORT_IF, ia, 1'b0, 8'h00, d + 5);
    driveReq(PORT_IF, ia, 1'b0, 8'h00);
    waitDone(PORT_IF);
    waitDone(PORT_IF);
    dropReq(PORT_IF);
  endtask

  task automatic resetTest();
    exp_t e;
    applyStimulus(PORT_LS, 8'd101, 1'b1, 8'h11);
    waitIdle();
    e.port = PORT_LS;
    e.addr = 8'd101;
    e.we = 1'b1;
    e.wdata = 8'h77;
    e.rdata = 8'h00;
    e.done_cyc = cyc + 2;
    exp_q.push_back(e);
    driveReq(PORT_LS, 8'd101, 1'b1, 8'h77);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_a", {24'd0, mem_a}, 32'd0);
    checkOutput("rst_mem_wd", {24'd0, mem_wd}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
    checkOutput("rst_if_rdata", {24'd0, if_rdata}, 32'd0);
    checkOutput("rst_ls_rdata", {24'd0, ls_rdata}, 32'd0);
    dropReq(PORT_LS);
    exp_q.delete();
    ref_last = PORT_LS;
    ref_ls_rdata = 8'h00;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("mem101_kept", {24'd0, mem[101]}, 32'h11);
    applyStimulus(PORT_LS, 8'd101, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[64] = 8'h3C;
    ref_mem[64] = 8'h3C;

    #1 reset = 1'b1;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset_mem_a", {24'd0, mem_a}, 32'd0);
    checkOutput("reset_dones", {30'd0, if_done, ls_done}, 32'd0);
    checkOutput("reset_rdata", {16'd0, if_rdata, ls_rdata}, 32'd0);

    runPair(1'b1, 8'd63, 1'b0, 8'd72, 8'h00);
    applyStimulus(PORT_IF, 8'd64, 1'b0, 8'h00);
    applyStimulus(PORT_LS, 8'd100, 1'b1, 8'hA5);
    applyStimulus(PORT_LS, 8'd100, 1'b0, 8'h00);
    applyStimulus(PORT_LS, 8'd7, 1'b1, 8'h5A);
    busyTest(8'd100, 8'd64);
    keepHighTest(8'd64);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: applyStimulus(PORT_IF, 8'($urandom), 1'b0, 8'h00);
        1: applyStimulus(PORT_LS, 8'($urandom_range(0, 15)), 1'($urandom), 8'($urandom));
        2: runPair(1'b0, 8'($urandom_range(0, 15)), 1'($urandom),
                   8'($urandom_range(0, 15)), 8'($urandom));
        default: repeat ($urandom_range(1, 3)) @(negedge clock);
      endcase
    end

    resetTest();
    runPair(1'b0, 8'd20, 1'b1, 8'd21, 8'hC3);
    waitIdle();
    repeat (3) @(negedge clock);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
